// File: rtl/gray_pkg.sv
// Gray-code helpers shared by the converter and counter blocks.
// The functions work on 32-bit zero-extended values, so callers of any width
// up to 32 cast their operand in and cast the result back down.
package gray_pkg;

  localparam int MAX_WIDTH = 32;

  // Binary to reflected Gray code.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray code to binary: each bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter used on the counter's load path.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out
);

  // Zero-extend, convert, and keep the low WIDTH bits.
  always_comb begin
    bin_out = WIDTH'(gray2bin(MAX_WIDTH'(gray_in)));
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter kept in binary, exposed in both binary and Gray code.
// Gray output is decoded from the binary register with no extra latency, so
// every count step flips exactly one Gray bit. wrap flags a counting step
// across the all-ones/zero boundary; loads never raise it.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH-1:0] load_bin;
  logic             at_max;
  logic             at_zero;

  gray2bin_conv #(
    .WIDTH(WIDTH)
  ) u_load_conv (
    .gray_in (load_gray),
    .bin_out (load_bin)
  );

  assign at_max  = (bin_q == '1);
  assign at_zero = (bin_q == '0);

  // Next count and wrap flag: load beats count-enable beats hold.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_d  = bin_q + WIDTH'(1);
        wrap_d = at_max;
      end else begin
        bin_d  = bin_q - WIDTH'(1);
        wrap_d = at_zero;
      end
    end
  end

  // All counter state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      wrap_q <= wrap_d;
    end
  end

  // Output decode; terminal count follows the live direction input.
  always_comb begin
    bin_out  = bin_q;
    gray_out = WIDTH'(bin2gray(MAX_WIDTH'(bin_q)));
    tc       = up_dn ? at_max : at_zero;
    wrap     = wrap_q;
  end

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en4, up4, ld4;
  logic [3:0] lg4, bin4, gray4;
  logic       tc4, wrap4;
  logic       en8, up8, ld8;
  logic [7:0] lg8, bin8, gray8;
  logic       tc8, wrap8;

  int   total = 0;
  int   bad   = 0;
  int   m4    = 0;   // reference count for the 4-bit instance
  logic ew4   = 1'b0; // reference wrap for the 4-bit instance

  gray_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .up_dn(up4), .load(ld4), .load_gray(lg4),
    .bin_out(bin4), .gray_out(gray4), .tc(tc4), .wrap(wrap4)
  );

  gray_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .up_dn(up8), .load(ld8), .load_gray(lg8),
    .bin_out(bin8), .gray_out(gray8), .tc(tc8), .wrap(wrap8)
  );

  always #5 clk = ~clk;

  // Reference inverse Gray mapping by exhaustive search over the code space.
  function automatic int g2b_ref(input int g, input int w);
    for (int b = 0; b < (1 << w); b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // Drive one cycle on the 4-bit instance and advance the reference model.
  task automatic step4(input logic e, input logic u, input logic l, input logic [3:0] g);
    int   nm;
    logic w;
    en4 = e; up4 = u; ld4 = l; lg4 = g;
    nm = m4;
    w  = 1'b0;
    if (l) begin
      nm = g2b_ref(int'(g), 4);
    end else if (e) begin
      if (u) begin
        w  = (m4 == 15);
        nm = (m4 + 1) % 16;
      end else begin
        w  = (m4 == 0);
        nm = (m4 + 15) % 16;
      end
    end
    @(posedge clk);
    #1;
    m4  = nm;
    ew4 = w;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en4 = 0; up4 = 1; ld4 = 0; lg4 = 4'hF;
    en8 = 0; up8 = 1; ld8 = 0; lg8 = 8'h00;
    #12;
    total++;
    if (bin4 !== 4'd0 || gray4 !== 4'd0 || wrap4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got bin=%b gray=%b wrap=%b want 0000 0000 0", bin4, gray4, wrap4);
    end
    total++;
    if (tc4 !== 1'b0) begin bad++; $display("FAIL reset_tc_up: got %b want 0", tc4); end
    up4 = 1'b0;
    #1;
    total++;
    if (tc4 !== 1'b1) begin bad++; $display("FAIL reset_tc_dn: got %b want 1", tc4); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m4 = 0; ew4 = 1'b0;
    step4(1'b0, 1'b1, 1'b0, 4'h0);
    total++;
    if (bin4 !== 4'd0) begin bad++; $display("FAIL post_reset_hold: got %0d want 0", bin4); end
  endtask

  task automatic test_count_up();
    logic [3:0] prev;
    for (int i = 0; i < 17; i++) begin
      en4 = 1'b1; up4 = 1'b1; ld4 = 1'b0;
      #1;
      total++;
      if (tc4 !== logic'(m4 == 15)) begin
        bad++; $display("FAIL up_tc step %0d: got %b want %b", i, tc4, (m4 == 15));
      end
      prev = gray4;
      step4(1'b1, 1'b1, 1'b0, 4'h0);
      total++;
      if (bin4 !== 4'(m4) || gray4 !== 4'(gray_of(m4)) || wrap4 !== ew4) begin
        bad++;
        $display("FAIL up_step %0d: got bin=%b gray=%b wrap=%b want bin=%b gray=%b wrap=%b",
                 i, bin4, gray4, wrap4, 4'(m4), 4'(gray_of(m4)), ew4);
      end
      total++;
      if ($countones(prev ^ gray4) != 1) begin
        bad++; $display("FAIL up_hamming step %0d: got %b->%b want one bit change", i, prev, gray4);
      end
    end
  endtask

  task automatic test_count_down_wrap();
    step4(1'b1, 1'b0, 1'b1, 4'b0000);
    up4 = 1'b0; en4 = 1'b1; ld4 = 1'b0;
    #1;
    total++;
    if (tc4 !== 1'b1 || wrap4 !== 1'b0) begin
      bad++; $display("FAIL dn_pre: got tc=%b wrap=%b want 1 0", tc4, wrap4);
    end
    step4(1'b1, 1'b0, 1'b0, 4'h0);
    total++;
    if (bin4 !== 4'b1111 || gray4 !== 4'b1000 || wrap4 !== 1'b1) begin
      bad++; $display("FAIL dn_wrap: got bin=%b gray=%b wrap=%b want 1111 1000 1", bin4, gray4, wrap4);
    end
    step4(1'b1, 1'b0, 1'b0, 4'h0);
    total++;
    if (bin4 !== 4'b1110 || wrap4 !== 1'b0) begin
      bad++; $display("FAIL dn_after: got bin=%b wrap=%b want 1110 0", bin4, wrap4);
    end
  endtask

  task automatic test_load_priority();
    step4(1'b1, 1'b1, 1'b1, 4'b1101);
    total++;
    if (bin4 !== 4'b1001 || gray4 !== 4'b1101 || wrap4 !== 1'b0) begin
      bad++; $display("FAIL load_prio: got bin=%b gray=%b wrap=%b want 1001 1101 0", bin4, gray4, wrap4);
    end
    // Loads moving between all-ones and zero never flag a wrap.
    step4(1'b0, 1'b1, 1'b1, 4'b1000);
    step4(1'b1, 1'b1, 1'b1, 4'b0000);
    total++;
    if (bin4 !== 4'd0 || wrap4 !== 1'b0) begin
      bad++; $display("FAIL load_no_wrap_up: got bin=%b wrap=%b want 0000 0", bin4, wrap4);
    end
    step4(1'b1, 1'b0, 1'b1, 4'b1000);
    total++;
    if (bin4 !== 4'b1111 || wrap4 !== 1'b0) begin
      bad++; $display("FAIL load_no_wrap_dn: got bin=%b wrap=%b want 1111 0", bin4, wrap4);
    end
  endtask

  task automatic test_load_all();
    for (int g = 0; g < 16; g++) begin
      step4(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b1, 4'(g));
      total++;
      if (bin4 !== 4'(g2b_ref(g, 4)) || gray4 !== 4'(g) || wrap4 !== 1'b0) begin
        bad++;
        $display("FAIL load_all g=%b: got bin=%b gray=%b wrap=%b want bin=%b gray=%b wrap=0",
                 4'(g), bin4, gray4, wrap4, 4'(g2b_ref(g, 4)), 4'(g));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] prev;
    logic       e, u, l;
    for (int i = 0; i < 300; i++) begin
      e = ($urandom_range(0, 3) != 0);
      u = logic'($urandom_range(0, 1));
      l = ($urandom_range(0, 7) == 0);
      prev = gray4;
      step4(e, u, l, 4'($urandom));
      total++;
      if (bin4 !== 4'(m4) || gray4 !== 4'(gray_of(m4)) || wrap4 !== ew4 ||
          tc4 !== (up4 ? logic'(m4 == 15) : logic'(m4 == 0))) begin
        bad++;
        $display("FAIL rand cycle %0d: got bin=%b gray=%b wrap=%b tc=%b want bin=%b gray=%b wrap=%b",
                 i, bin4, gray4, wrap4, tc4, 4'(m4), 4'(gray_of(m4)), ew4);
      end
      total++;
      if (gray4 !== (bin4 ^ (bin4 >> 1))) begin
        bad++; $display("FAIL rand_relation cycle %0d: got gray=%b bin=%b", i, gray4, bin4);
      end
      if (e && !l) begin
        total++;
        if ($countones(prev ^ gray4) != 1) begin
          bad++; $display("FAIL rand_hamming cycle %0d: got %b->%b want one bit change", i, prev, gray4);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    step4(1'b0, 1'b1, 1'b1, 4'b0111);
    total++;
    if (bin4 !== 4'd5) begin bad++; $display("FAIL ar_setup: got %0d want 5", bin4); end
    #3;
    ld4 = 1'b1; lg4 = 4'b1111; en4 = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if (bin4 !== 4'd0 || gray4 !== 4'd0 || wrap4 !== 1'b0 || tc4 !== ~up4) begin
      bad++; $display("FAIL ar_immediate: got bin=%b gray=%b wrap=%b tc=%b want 0000 0000 0 %b",
                      bin4, gray4, wrap4, tc4, ~up4);
    end
    @(posedge clk);
    #1;
    total++;
    if (bin4 !== 4'd0 || gray4 !== 4'd0) begin
      bad++; $display("FAIL ar_load_discard: got bin=%b gray=%b want 0000 0000", bin4, gray4);
    end
    rst = 1'b0; ld4 = 1'b0; en4 = 1'b0;
    m4 = 0; ew4 = 1'b0;
    // Reset landing while a wrap pulse is high clears it at once.
    step4(1'b1, 1'b0, 1'b0, 4'h0);
    total++;
    if (wrap4 !== 1'b1) begin bad++; $display("FAIL ar_wrap_setup: got %b want 1", wrap4); end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (wrap4 !== 1'b0 || bin4 !== 4'd0) begin
      bad++; $display("FAIL ar_wrap_clear: got wrap=%b bin=%b want 0 0000", wrap4, bin4);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m4 = 0; ew4 = 1'b0;
    step4(1'b0, 1'b1, 1'b0, 4'h0);
    step4(1'b1, 1'b1, 1'b0, 4'h0);
    total++;
    if (bin4 !== 4'd1 || wrap4 !== 1'b0) begin
      bad++; $display("FAIL ar_first_step: got bin=%b wrap=%b want 0001 0", bin4, wrap4);
    end
  endtask

  task automatic test_dir_toggle8();
    logic [7:0] prev, exp;
    en8 = 1'b0; ld8 = 1'b1; lg8 = 8'h40; up8 = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bin8 !== 8'h7F) begin bad++; $display("FAIL w8_load: got %h want 7f", bin8); end
    ld8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      up8 = (i % 2 == 0);
      en8 = 1'b1;
      exp = up8 ? 8'h80 : 8'h7F;
      prev = gray8;
      @(posedge clk);
      #1;
      total++;
      if (bin8 !== exp || gray8 !== 8'(gray_of(int'(exp))) || wrap8 !== 1'b0) begin
        bad++; $display("FAIL w8_toggle %0d: got bin=%h gray=%h wrap=%b want bin=%h gray=%h wrap=0",
                        i, bin8, gray8, wrap8, exp, 8'(gray_of(int'(exp))));
      end
      total++;
      if ($countones(prev ^ gray8) != 1) begin
        bad++; $display("FAIL w8_hamming %0d: got %h->%h want one bit change", i, prev, gray8);
      end
    end
    en8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down_wrap();
    test_load_priority();
    test_load_all();
    test_random();
    test_async_reset();
    test_dir_toggle8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and code width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  count enable; one step per clk edge while high.
REQ-005 Port: up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 Port: load  input  1  synchronous load strobe.
REQ-007 Port: load_gray  input  WIDTH  Gray-coded value to load.
REQ-008 Port: bin_out  output  WIDTH  registered count, binary.
REQ-009 Port: gray_out  output  WIDTH  registered count, Gray code.
REQ-010 Port: tc  output  1  terminal count, combinational from registered count and up_dn.
REQ-011 Port: wrap  output  1  registered one-cycle pulse on wrap-around.

Function
REQ-012 Count state SHALL be held as a WIDTH-bit binary register; gray_out SHALL always equal bin_out ^ (bin_out >> 1) in the same cycle, with no extra latency.
REQ-013 Priority per edge: load > en > hold.
REQ-014 load=1: next binary = Gray-to-binary of load_gray (b[W-1]=g[W-1], b[i]=b[i+1]^g[i]); visible on outputs the next cycle (1-cycle latency); en ignored that cycle.
REQ-015 load=0, en=1, up_dn=1: next = bin_out+1 modulo 2^WIDTH.
REQ-016 load=0, en=1, up_dn=0: next = bin_out-1 modulo 2^WIDTH.
REQ-017 load=0, en=0: count, gray_out and bin_out hold.
REQ-018 Every counting step SHALL change exactly one bit of gray_out, wrap steps included.
REQ-019 tc SHALL be 1 when (up_dn=1 and bin_out=2^WIDTH-1) or (up_dn=0 and bin_out=0); else 0; independent of en.
REQ-020 wrap SHALL be 1 for exactly the cycle after a counting step from all-ones to 0 (up) or from 0 to all-ones (down); otherwise 0.
REQ-021 A load SHALL never assert wrap, even when it moves the count between 0 and all-ones.
REQ-022 A direction change SHALL take effect on the same edge it is sampled; no dead cycle.

Reset
REQ-023 rst=1 SHALL asynchronously force bin_out=0, gray_out=0 and wrap=0, independent of clk.
REQ-024 While rst=1, tc SHALL reflect count 0 (tc = ~up_dn).
REQ-025 Reset asserted mid-count or coincident with load SHALL win; the load is discarded.
REQ-026 After rst deasserts, the first step SHALL occur on the first clk edge with en=1 or load=1.

Structure
REQ-027 Shared package gray_pkg SHALL hold bin2gray and gray2bin functions, parameterised via WIDTH-agnostic loops, for reuse across converter and counter blocks.
REQ-028 One sub-module is natural: gray2bin_conv (combinational, WIDTH-parameterised) used on the load path; no other hierarchy.
REQ-029 All sequential logic SHALL sit in a single always block sensitive to posedge clk and posedge rst.

Verification
REQ-030 WIDTH=4, reset, en=1, up_dn=1 for 17 cycles -> gray_out sequence 0000,0001,0011,0010,0110,...,1000,0000; wrap=1 the cycle after 1000->0000; tc=1 while bin_out=1111.
REQ-031 WIDTH=4, count 0, en=1, up_dn=0 -> bin_out 1111, gray_out 1000, wrap=1 for one cycle; tc=1 before the step.
REQ-032 WIDTH=4, load=1, load_gray=1101, en=1 same cycle -> next bin_out=1001, gray_out=1101; no increment, wrap=0.
REQ-033 WIDTH=8, count 0x7F, toggle up_dn every cycle with en=1 -> bin_out alternates 0x80/0x7F; gray_out Hamming distance 1 every step.
REQ-034 Assert rst between clk edges at count 0x5 -> outputs 0 immediately, before the next clk edge; simultaneous load discarded.
REQ-035 WIDTH=4, all 16 load_gray values loaded -> bin_out matches reference gray2bin, gray_out equals load_gray; self-check all cycles that gray_out == bin_out ^ (bin_out >> 1).
